butterfly_pipe: RTL and testbench
=================================

Name: butterfly_pipe

Overview:
Pipelined, parametrised radix-2 DIT butterfly that computes out0 = A + B·W and out1 = A − B·W on packed complex fixed-point samples.
- Adds over the combinational butterfly: twiddle fixed-point scaling with rounding, optional per-stage ÷2 scaling, conjugate-twiddle (inverse FFT) mode, saturation with a sticky overflow flag, and valid/ready flow control.
- Sits between the FFT stage sequencer and the twiddle ROM; one instance per stage lane.

Parameters:
- WIDTH, 32, packed complex word width; real part in [WIDTH-1:HALF], imag part in [HALF-1:0], HALF = WIDTH/2. WIDTH must be even.
- TW_FRAC, 14, fractional bits of twiddle components (signed Q1.TW_FRAC in HALF bits; +1.0 = 2^TW_FRAC). Must be ≤ HALF-2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  A/B/W/inverse/scale valid.
- in_ready  out  1  block accepts input this cycle.
- a  in  WIDTH  complex operand A.
- b  in  WIDTH  complex operand B.
- w  in  WIDTH  complex twiddle W.
- inverse  in  1  1: use conj(W), i.e. imag negated; sampled with data.
- scale  in  1  1: divide both outputs by 2 with rounding; sampled with data.
- out_valid  out  1  out0/out1 valid.
- out_ready  in  1  downstream accepts output.
- out0  out  WIDTH  A + B·W (packed).
- out1  out  WIDTH  A − B·W (packed).
- ovf  out  1  sticky saturation flag.
- ovf_clr  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0, out_valid=0, out0=out1=0, ovf=0. in_ready=1 the cycle after release. Reset mid-operation discards all in-flight data; no partial output.
- Pipeline, 3 register stages, latency 3 cycles input-accept to out_valid when not stalled; throughput 1 per cycle.
  - S1: register a, b, w (w imag negated if inverse; −(−2^(HALF-1)) saturates to 2^(HALF-1)−1), scale.
  - S2: 4 signed HALF×HALF products; pr = Br·Wr − Bi·Wi, pi = Br·Wi + Bi·Wr at 2·HALF+1 bits; round half-up: t = (p + 2^(TW_FRAC−1)) >>> TW_FRAC, kept at HALF+2 bits. A carried alongside.
  - S3: s0 = A ± t per component at HALF+3 bits. If scale: s = (s + 1) >>> 1. Saturate each component to [−2^(HALF-1), 2^(HALF-1)−1]; pack real/imag into out0/out1.
- Flow control: advance = !out_valid || out_ready.
  - in_ready = advance. All stages shift together on advance; bubbles are not squeezed.
  - Input is accepted only when in_valid && in_ready.
  - While out_valid && !out_ready: out0/out1/out_valid are held stable and no stage moves.
- Ordering: strictly in-order; no drop, no duplication.
- ovf: set on the cycle any component of an output being loaded into S3 saturates. ovf_clr clears it. If set and clear occur in the same cycle, set wins. ovf is not cleared by stalls.
- Arithmetic is two's complement; intermediate widths above are mandatory to avoid internal wrap.

Decomposition:
- Shared package fft_pkg:
  - HALF-derived localparams.
  - typedef cplx_t: struct of signed re/im.
  - Functions sat_half(), round_shift(), pack_cplx(), unpack_cplx().
- One sub-module, cmul_round: S1→S2 complex multiply, conjugate option, and rounding. Add/scale/saturate stays in butterfly_pipe.

Test Plan (WIDTH=32, TW_FRAC=14, out_ready=1 unless stated):
- A=(100,50), B=(20,−10), W=(16384,0), inverse=0, scale=0 -> 3 cycles later out0=(120,40), out1=(80,60), ovf=0.
- Same A, B, W=(0,−16384) (−j) -> out0=(90,30), out1=(110,70); same with inverse=1 -> out0=(110,70), out1=(90,30).
- A=(32767,0), B=(1000,0), W=(16384,0), scale=0 -> out0=(32767,0) saturated, out1=(31767,0), ovf=1. Then pulse ovf_clr -> ovf=0 next cycle. ovf_clr coincident with a new saturation -> ovf stays 1.
- Same operands with scale=1 -> out0=(16884,0), out1=(15884,0), ovf=0.
- Back-to-back stream of 8 vectors, out_ready=0 for 5 cycles mid-stream -> in_ready drops when the pipe is full, outputs held stable while stalled, all 8 results emerge in order with no loss or duplication.
- Assert rst_n=0 with 2 vectors in flight -> out_valid=0, out0=out1=0 immediately. After release, no stale output appears; a new vector emerges 3 cycles after acceptance.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and fixed-point helpers for the radix-2 butterfly datapath.
// Word geometry is fixed here; butterfly_pipe refuses any other WIDTH/TW_FRAC.
package fft_pkg;

   localparam int C_WIDTH   = 32;
   localparam int C_TW_FRAC = 14;
   localparam int HALF      = C_WIDTH / 2;
   localparam int PW        = 2*HALF + 1;   // sum of two products
   localparam int TW        = HALF + 2;     // rounded product
   localparam int SW        = HALF + 3;     // butterfly sum

   typedef struct packed {
      logic signed [HALF-1:0] re;
      logic signed [HALF-1:0] im;
   } cplx_t;

   typedef struct packed {
      logic signed [TW-1:0] re;
      logic signed [TW-1:0] im;
   } prod_t;

   localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (HALF-1)) - 1);
   localparam logic signed [SW-1:0] SAT_MIN = SW'(-(1 << (HALF-1)));

   function automatic logic sat_hit(input logic signed [SW-1:0] x);
      return (x > SAT_MAX) || (x < SAT_MIN);
   endfunction

   function automatic logic signed [HALF-1:0] sat_half(input logic signed [SW-1:0] x);
      if (x > SAT_MAX)      return SAT_MAX[HALF-1:0];
      else if (x < SAT_MIN) return SAT_MIN[HALF-1:0];
      else                  return x[HALF-1:0];
   endfunction

   // Round half-up, then drop the twiddle fraction bits.
   function automatic logic signed [TW-1:0] round_shift(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] r;
      r = p + PW'(1 << (C_TW_FRAC-1));
      r = r >>> C_TW_FRAC;
      return r[TW-1:0];
   endfunction

   function automatic logic [C_WIDTH-1:0] pack_cplx(input cplx_t c);
      return {c.re, c.im};
   endfunction

   function automatic cplx_t unpack_cplx(input logic [C_WIDTH-1:0] x);
      cplx_t c;
      c.re = x[C_WIDTH-1:HALF];
      c.im = x[HALF-1:0];
      return c;
   endfunction

endpackage

// File: rtl/cmul_round.sv
// Stages S1/S2 of the butterfly: registers B and (optionally conjugated) W,
// then forms B*W and rounds it back to twiddle-free scale.
module cmul_round
   import fft_pkg::*;
(
   input  logic               clk,
   input  logic               en,
   input  logic [C_WIDTH-1:0] b,
   input  logic [C_WIDTH-1:0] w,
   input  logic               inverse,
   output prod_t              t
);

   cplx_t b_in, w_in, b1_q, w1_q;
   prod_t t_q;
   logic signed [2*HALF-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [PW-1:0]     pr, pi;

   // NOTE: w_in is fully assigned before being patched, so no latch is inferred.
   always_comb begin
      b_in = unpack_cplx(b);
      w_in = unpack_cplx(w);
      if (inverse) w_in.im = sat_half(-SW'(w_in.im));
   end

   assign p_rr = (2*HALF)'(b1_q.re) * (2*HALF)'(w1_q.re);
   assign p_ii = (2*HALF)'(b1_q.im) * (2*HALF)'(w1_q.im);
   assign p_ri = (2*HALF)'(b1_q.re) * (2*HALF)'(w1_q.im);
   assign p_ir = (2*HALF)'(b1_q.im) * (2*HALF)'(w1_q.re);
   assign pr   = PW'(p_rr) - PW'(p_ii);
   assign pi   = PW'(p_ri) + PW'(p_ir);

   // NOTE: pure data registers carry no reset; validity is tracked by the top's valid bits.
   always_ff @(posedge clk) begin
      if (en) begin
         b1_q    <= b_in;
         w1_q    <= w_in;
         t_q.re  <= round_shift(pr);
         t_q.im  <= round_shift(pi);
      end
   end

   assign t = t_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage radix-2 DIT butterfly: out0 = A + B*W, out1 = A - B*W, with
// optional /2 scaling, saturation, sticky overflow and valid/ready flow control.
module butterfly_pipe
   import fft_pkg::*;
#(
   parameter int WIDTH   = C_WIDTH,
   parameter int TW_FRAC = C_TW_FRAC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] w,
   input  logic             inverse,
   input  logic             scale,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic             ovf,
   input  logic             ovf_clr
);

   if (WIDTH != C_WIDTH || TW_FRAC != C_TW_FRAC || C_TW_FRAC > HALF-2) begin : g_cfg_check
      $error("butterfly_pipe: WIDTH/TW_FRAC must match fft_pkg");
   end

   logic                 advance;
   logic                 v1_q, v2_q, out_valid_q, ovf_q, ovf_d, sat_d;
   logic                 sc1_q, sc2_q;
   cplx_t                a1_q, a2_q, o0_d, o1_d, o0_q, o1_q;
   prod_t                t2;
   logic signed [SW-1:0] s0r, s0i, s1r, s1i;

   function automatic logic signed [SW-1:0] scale_round(input logic signed [SW-1:0] s,
                                                        input logic sc);
      return sc ? ((s + SW'(1)) >>> 1) : s;
   endfunction

   // Stalls freeze every stage at once; bubbles are never squeezed out.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = advance;

   cmul_round u_cmul (
      .clk     (clk),
      .en      (advance),
      .b       (b),
      .w       (w),
      .inverse (inverse),
      .t       (t2)
   );

   always_ff @(posedge clk) begin
      if (advance) begin
         a1_q  <= unpack_cplx(a);
         sc1_q <= scale;
         a2_q  <= a1_q;
         sc2_q <= sc1_q;
      end
   end

   assign s0r = scale_round(SW'(a2_q.re) + SW'(t2.re), sc2_q);
   assign s0i = scale_round(SW'(a2_q.im) + SW'(t2.im), sc2_q);
   assign s1r = scale_round(SW'(a2_q.re) - SW'(t2.re), sc2_q);
   assign s1i = scale_round(SW'(a2_q.im) - SW'(t2.im), sc2_q);

   assign o0_d  = '{re: sat_half(s0r), im: sat_half(s0i)};
   assign o1_d  = '{re: sat_half(s1r), im: sat_half(s1i)};
   assign sat_d = sat_hit(s0r) | sat_hit(s0i) | sat_hit(s1r) | sat_hit(s1i);

   // A new saturation outranks a coincident clear.
   assign ovf_d = (advance && v2_q && sat_d) || (ovf_q && !ovf_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         out_valid_q <= 1'b0;
         o0_q        <= '0;
         o1_q        <= '0;
         ovf_q       <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         if (advance) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
               o0_q <= o0_d;
               o1_q <= o1_d;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out0      = pack_cplx(o0_q);
   assign out1      = pack_cplx(o1_q);
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: hand-computed vectors, stall and reset scenarios.
module tb_butterfly_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0, b = '0, w = '0;
   logic        inverse = 1'b0, scale = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out0, out1;
   logic        ovf;
   logic        ovf_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   butterfly_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .w         (w),
      .inverse   (inverse),
      .scale     (scale),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out0      (out0),
      .out1      (out1),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   function automatic logic [31:0] cx(input int re, input int im);
      logic [31:0] r;
      r = {re[15:0], im[15:0]};
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one vector, then counts edges until out_valid (bounded).
   task automatic run_vec(input logic [31:0] av, bv, wv, input logic inv, sc, output int lat);
      a = av; b = bv; w = wv; inverse = inv; scale = sc; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      tick(); tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      total++; if (out0 !== 32'h0) begin bad++; $display("FAIL reset_out0: got %h expected 0", out0); end
      total++; if (out1 !== 32'h0) begin bad++; $display("FAIL reset_out1: got %h expected 0", out1); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
      rst_n = 1'b1;
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_identity();
      int lat;
      run_vec(cx(100, 50), cx(20, -10), cx(16384, 0), 1'b0, 1'b0, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL ident_latency: got %0d expected 3", lat); end
      total++; if (out0 !== cx(120, 40)) begin bad++; $display("FAIL ident_out0: got %h expected %h", out0, cx(120, 40)); end
      total++; if (out1 !== cx(80, 60)) begin bad++; $display("FAIL ident_out1: got %h expected %h", out1, cx(80, 60)); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ident_ovf: got %b expected 0", ovf); end
      tick();
   endtask

   task automatic test_twiddle();
      int lat;
      run_vec(cx(100, 50), cx(20, -10), cx(0, -16384), 1'b0, 1'b0, lat);
      total++; if (out0 !== cx(90, 30)) begin bad++; $display("FAIL negj_out0: got %h expected %h", out0, cx(90, 30)); end
      total++; if (out1 !== cx(110, 70)) begin bad++; $display("FAIL negj_out1: got %h expected %h", out1, cx(110, 70)); end
      tick();
      run_vec(cx(100, 50), cx(20, -10), cx(0, -16384), 1'b1, 1'b0, lat);
      total++; if (out0 !== cx(110, 70)) begin bad++; $display("FAIL inv_out0: got %h expected %h", out0, cx(110, 70)); end
      total++; if (out1 !== cx(90, 30)) begin bad++; $display("FAIL inv_out1: got %h expected %h", out1, cx(90, 30)); end
      tick();
      // conj of imag -32768 must saturate to +32767: B*W = (-32767/16384) -> -2
      run_vec(cx(0, 0), cx(0, 1), cx(0, -32768), 1'b1, 1'b0, lat);
      total++; if (out0 !== cx(-2, 0)) begin bad++; $display("FAIL conj_sat_out0: got %h expected %h", out0, cx(-2, 0)); end
      total++; if (out1 !== cx(2, 0)) begin bad++; $display("FAIL conj_sat_out1: got %h expected %h", out1, cx(2, 0)); end
      tick();
   endtask

   task automatic test_rounding();
      int lat;
      run_vec(cx(0, 0), cx(1, 0), cx(8192, 0), 1'b0, 1'b0, lat);   // +0.5 rounds up to 1
      total++; if (out0 !== cx(1, 0)) begin bad++; $display("FAIL round_pos_out0: got %h expected %h", out0, cx(1, 0)); end
      total++; if (out1 !== cx(-1, 0)) begin bad++; $display("FAIL round_pos_out1: got %h expected %h", out1, cx(-1, 0)); end
      tick();
      run_vec(cx(0, 0), cx(-1, 0), cx(8192, 0), 1'b0, 1'b0, lat);  // -0.5 rounds up to 0
      total++; if (out0 !== cx(0, 0)) begin bad++; $display("FAIL round_neg_out0: got %h expected %h", out0, cx(0, 0)); end
      tick();
      run_vec(cx(10, 10), cx(0, 3), cx(0, 8192), 1'b0, 1'b0, lat);  // real -1.5 -> -1
      total++; if (out0 !== cx(9, 10)) begin bad++; $display("FAIL round_im_out0: got %h expected %h", out0, cx(9, 10)); end
      total++; if (out1 !== cx(11, 10)) begin bad++; $display("FAIL round_im_out1: got %h expected %h", out1, cx(11, 10)); end
      tick();
   endtask

   task automatic test_saturation();
      int lat;
      run_vec(cx(32767, 0), cx(1000, 0), cx(16384, 0), 1'b0, 1'b0, lat);
      total++; if (out0 !== cx(32767, 0)) begin bad++; $display("FAIL sat_out0: got %h expected %h", out0, cx(32767, 0)); end
      total++; if (out1 !== cx(31767, 0)) begin bad++; $display("FAIL sat_out1: got %h expected %h", out1, cx(31767, 0)); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf_set: got %b expected 1", ovf); end
      tick(); tick(); tick();
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_ovf_sticky: got %b expected 1", ovf); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sat_ovf_clr: got %b expected 0", ovf); end
      ovf_clr = 1'b1;
      run_vec(cx(32767, 0), cx(1000, 0), cx(16384, 0), 1'b0, 1'b0, lat);
      ovf_clr = 1'b0;
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL sat_set_wins: got %b expected 1", ovf); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      run_vec(cx(-32768, 5), cx(1000, 0), cx(16384, 0), 1'b0, 1'b0, lat);
      total++; if (out0 !== cx(-31768, 5)) begin bad++; $display("FAIL satneg_out0: got %h expected %h", out0, cx(-31768, 5)); end
      total++; if (out1 !== cx(-32768, 5)) begin bad++; $display("FAIL satneg_out1: got %h expected %h", out1, cx(-32768, 5)); end
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL satneg_ovf: got %b expected 1", ovf); end
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
   endtask

   task automatic test_scale();
      int lat;
      run_vec(cx(32767, 0), cx(1000, 0), cx(16384, 0), 1'b0, 1'b1, lat);
      total++; if (out0 !== cx(16884, 0)) begin bad++; $display("FAIL scale_out0: got %h expected %h", out0, cx(16884, 0)); end
      total++; if (out1 !== cx(15884, 0)) begin bad++; $display("FAIL scale_out1: got %h expected %h", out1, cx(15884, 0)); end
      total++; if (ovf !== 1'b0) begin bad++; $display("FAIL scale_ovf: got %b expected 0", ovf); end
      tick();
      run_vec(cx(-5, 7), cx(0, 0), cx(16384, 0), 1'b0, 1'b1, lat);
      total++; if (out0 !== cx(-2, 4)) begin bad++; $display("FAIL scale_round_out0: got %h expected %h", out0, cx(-2, 4)); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] va[8], vb[8], vw[8], e0[8], e1[8];
      logic [31:0] held0 = '0, held1 = '0;
      logic        prev_stall = 1'b0, saw_block = 1'b0, acc, xfer, extra;
      int          sent = 0, got = 0, cyc = 0;
      for (int k = 0; k < 8; k++) begin
         int i;
         i = k + 1;
         va[k] = cx(10*i, -i);
         vb[k] = cx(i, 2*i);
         if (k % 2 == 0) begin
            vw[k] = cx(16384, 0);
            e0[k] = cx(11*i, i);
            e1[k] = cx(9*i, -3*i);
         end else begin
            vw[k] = cx(0, 16384);
            e0[k] = cx(8*i, 0);
            e1[k] = cx(12*i, -2*i);
         end
      end
      inverse = 1'b0; scale = 1'b0;
      while ((sent < 8 || got < 8) && cyc < 60) begin
         out_ready = !(cyc >= 4 && cyc < 9);
         in_valid  = (sent < 8);
         if (sent < 8) begin a = va[sent]; b = vb[sent]; w = vw[sent]; end
         #1;
         acc  = in_valid && in_ready;
         xfer = out_valid && out_ready;
         if (!in_ready) saw_block = 1'b1;
         if (prev_stall) begin
            total++;
            if (!out_valid || out0 !== held0 || out1 !== held1) begin
               bad++; $display("FAIL b2b_hold: got %b/%h/%h expected 1/%h/%h", out_valid, out0, out1, held0, held1);
            end
         end
         prev_stall = out_valid && !out_ready;
         held0 = out0; held1 = out1;
         if (xfer) begin
            total++;
            if (got >= 8) begin
               bad++; $display("FAIL b2b_extra: got output %0d expected at most 8", got + 1);
            end else if (out0 !== e0[got] || out1 !== e1[got]) begin
               bad++; $display("FAIL b2b_data[%0d]: got %h/%h expected %h/%h", got, out0, out1, e0[got], e1[got]);
            end
            got++;
         end
         if (acc) sent++;
         tick();
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++; if (sent !== 8 || got !== 8) begin bad++; $display("FAIL b2b_count: got sent=%0d recv=%0d expected 8/8", sent, got); end
      total++; if (saw_block !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_drop: got %b expected 1", saw_block); end
      extra = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (out_valid) extra = 1'b1;
         tick();
      end
      total++; if (extra !== 1'b0) begin bad++; $display("FAIL b2b_duplicate: got %b expected 0", extra); end
   endtask

   task automatic test_reset_midflight();
      int   lat;
      logic stale;
      a = cx(100, 50); b = cx(20, -10); w = cx(16384, 0); inverse = 1'b0; scale = 1'b0;
      in_valid = 1'b1;
      tick();
      a = cx(7, 7);
      tick();
      in_valid = 1'b0;
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid: got %b expected 1", out_valid); end
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
      total++; if (out0 !== 32'h0 || out1 !== 32'h0) begin bad++; $display("FAIL rstmid_data: got %h/%h expected 0/0", out0, out1); end
      tick();
      rst_n = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      total++; if (stale !== 1'b0) begin bad++; $display("FAIL rstmid_stale: got %b expected 0", stale); end
      run_vec(cx(1, 2), cx(3, 4), cx(16384, 0), 1'b0, 1'b0, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL rstmid_latency: got %0d expected 3", lat); end
      total++; if (out0 !== cx(4, 6) || out1 !== cx(-2, -2)) begin
         bad++; $display("FAIL rstmid_new: got %h/%h expected %h/%h", out0, out1, cx(4, 6), cx(-2, -2));
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_identity();
      test_twiddle();
      test_rounding();
      test_saturation();
      test_scale();
      test_back_to_back();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
